// File: rtl/mod_n_updown_counter.sv
// Multi-digit modulo-N up/down counter with parallel load, combinational
// terminal count for chaining, registered full-wrap pulse and sticky load error.
module mod_n_updown_counter #(
  parameter int N      = 10,
  parameter int DIGITS = 2,
  localparam int W     = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [DIGITS*W-1:0] d,
  output logic [DIGITS*W-1:0] q,
  output logic                tc,
  output logic                wrap,
  output logic                err
);

  localparam logic [W-1:0] TOP  = W'(N - 1);
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [DIGITS*W-1:0] count_q, count_d;
  logic [DIGITS*W-1:0] step_val, load_val;
  logic                wrap_q, wrap_d;
  logic                err_q, err_d;
  logic                all_term, load_bad;
  logic [W-1:0]        digit, in_dig, step_dig;

  // Ripple-carry step, load sanitising and next-state selection (load over count over hold)
  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    err_d    = err_q;
    all_term = 1'b1;
    load_bad = 1'b0;
    step_val = {(DIGITS*W){1'b0}};
    load_val = {(DIGITS*W){1'b0}};
    digit    = ZERO;
    in_dig   = ZERO;
    step_dig = ZERO;
    for (int k = 0; k < DIGITS; k++) begin
      digit  = count_q[k*W +: W];
      in_dig = d[k*W +: W];
      if (int'(in_dig) < N) begin
        load_val[k*W +: W] = in_dig;
      end else begin
        load_val[k*W +: W] = ZERO;
        load_bad           = 1'b1;
      end
      // Wrap is compared explicitly; N need not be a power of two.
      if (up) begin
        step_dig = (digit == TOP) ? ZERO : digit + W'(1);
      end else begin
        step_dig = (digit == ZERO) ? TOP : digit - W'(1);
      end
      // all_term here still covers only the lower digits: it is the carry/borrow in.
      if (all_term) begin
        step_val[k*W +: W] = step_dig;
      end else begin
        step_val[k*W +: W] = digit;
      end
      all_term = all_term & (up ? (digit == TOP) : (digit == ZERO));
    end
    if (load) begin
      count_d = load_val;
      err_d   = err_q | load_bad;
    end else if (en) begin
      count_d = step_val;
      wrap_d  = all_term;
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {(DIGITS*W){1'b0}};
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign q    = count_q;
  assign wrap = wrap_q;
  assign err  = err_q;
  assign tc   = en & ~load & all_term;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Randomized + directed scoreboard bench: two counters (N=10/2 digits, N=6/3 digits)
// checked against an integer-valued reference model.
module tb_mod_n_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic [8:0] d1 = 9'h000;
  logic [7:0] q0;
  logic [8:0] q1;
  logic       tc0, tc1, wrap0, wrap1, err0, err1;

  always #5 clk = ~clk;

  mod_n_updown_counter #(.N(10), .DIGITS(2)) dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .d(d0), .q(q0), .tc(tc0), .wrap(wrap0), .err(err0));

  mod_n_updown_counter #(.N(6), .DIGITS(3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .d(d1), .q(q1), .tc(tc1), .wrap(wrap1), .err(err1));

  typedef struct packed {
    logic        tc;
    logic [31:0] q;
    logic        wrap;
    logic        err;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int  compared   = 0;
  int  mismatched = 0;
  bit  track      = 1'b0;

  // Reference model: each counter is a single integer modulo N**DIGITS
  int  nn[2] = '{10, 6};
  int  dg[2] = '{2, 3};
  int  ww[2] = '{4, 3};
  int  mv[2];
  bit  mwrap[2];
  bit  merr[2];

  function automatic int modulus(input int i);
    int m = 1;
    for (int k = 0; k < dg[i]; k++) m = m * nn[i];
    return m;
  endfunction

  function automatic logic [31:0] pack(input int i, input int v);
    logic [31:0] r = 32'd0;
    int rem = v;
    for (int k = 0; k < dg[i]; k++) begin
      r = r | (32'(rem % nn[i]) << (k * ww[i]));
      rem = rem / nn[i];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_step(input int i, input logic r, input logic l, input logic e,
                            input logic u, input logic [31:0] dv);
    int   m = modulus(i);
    exp_t x;
    int   val, wt, dig;
    bit   bad;
    x.tc   = e & ~l & (u ? (mv[i] == m - 1) : (mv[i] == 0));
    x.q    = pack(i, mv[i]);
    x.wrap = mwrap[i];
    x.err  = merr[i];
    if (i == 0) sb0.push_back(x); else sb1.push_back(x);
    if (r) begin
      mv[i] = 0; mwrap[i] = 1'b0; merr[i] = 1'b0;
    end else if (l) begin
      val = 0; wt = 1; bad = 1'b0;
      for (int k = 0; k < dg[i]; k++) begin
        dig = int'((dv >> (k * ww[i])) & ((32'd1 << ww[i]) - 32'd1));
        if (dig >= nn[i]) begin
          bad = 1'b1;
          dig = 0;
        end
        val = val + dig * wt;
        wt  = wt * nn[i];
      end
      mv[i] = val; mwrap[i] = 1'b0; merr[i] = merr[i] | bad;
    end else if (e) begin
      if (u) begin
        mwrap[i] = (mv[i] == m - 1);
        mv[i]    = (mv[i] + 1) % m;
      end else begin
        mwrap[i] = (mv[i] == 0);
        mv[i]    = (mv[i] + m - 1) % m;
      end
    end else begin
      mwrap[i] = 1'b0;
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic u,
                       input logic [7:0] a, input logic [8:0] b);
    @(posedge clk);
    #1;
    rst = r; load = l; en = e; up = u; d0 = a; d1 = b;
    if (track) begin
      model_step(0, r, l, e, u, {24'd0, a});
      model_step(1, r, l, e, u, {23'd0, b});
    end
  endtask

  // Monitor: pops one expectation per instance per cycle and compares mid-cycle
  always @(negedge clk) begin
    exp_t x;
    if (sb0.size() > 0) begin
      x = sb0.pop_front();
      chk("q0", {24'd0, q0}, x.q);
      chk("tc0", {31'd0, tc0}, {31'd0, x.tc});
      chk("wrap0", {31'd0, wrap0}, {31'd0, x.wrap});
      chk("err0", {31'd0, err0}, {31'd0, x.err});
    end
    if (sb1.size() > 0) begin
      x = sb1.pop_front();
      chk("q1", {23'd0, q1}, x.q);
      chk("tc1", {31'd0, tc1}, {31'd0, x.tc});
      chk("wrap1", {31'd0, wrap1}, {31'd0, x.wrap});
      chk("err1", {31'd0, err1}, {31'd0, x.err});
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mwrap[i] = 1'b0; merr[i] = 1'b0;
    end
    track = 1'b1;
    // Up sweep: 220 counts wraps the 2-digit counter twice and the 3-digit one once
    repeat (220) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 9'h000);
    // Down through 00 -> 99 and the 90 -> 89 borrow
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 9'h000);
    repeat (15) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 9'h000);
    // Load with en high, then count
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h47, 9'o234);
    repeat (10) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 9'h000);
    // Hold for 3 cycles, then reverse direction
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 9'h000);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 9'h000);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 9'h000);
    // Out-of-range digits: sanitised to 0 and err sticks
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 9'o701);
    repeat (5) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 9'h000);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 9'o123);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 9'h000);
    // Reset on the terminal-count cycle suppresses the wrap pulse
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 9'o555);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 9'h000);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 9'h000);
    // Randomised traffic
    repeat (3000) begin
      drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
            8'($urandom), 9'($urandom));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 9'h000);
    track = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    if ((sb0.size() != 0) || (sb1.size() != 0)) begin
      mismatched++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0/0", sb0.size(), sb1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
